// File: rtl/fb_pkg.sv
// Shared framebuffer-arbiter defaults and the grant encoding.
package fb_pkg;

   localparam int unsigned FB_ADDR_W = 16;
   localparam int unsigned FB_DATA_W = 8;

   typedef enum logic [1:0] {
      G_NONE = 2'd0,
      G_RD   = 2'd1,
      G_WR   = 2'd2
   } grant_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a registered occupancy count; head is presented combinationally.
module sync_fifo #(
   parameter int unsigned WIDTH = 24,
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [WIDTH-1:0]         din,
   input  logic                     pop,
   output logic [WIDTH-1:0]         dout,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     full,
   output logic                     empty
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned LW = PW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [LW-1:0]    level_q, level_d;
   logic             do_push, do_pop;

   assign full  = (level_q == LW'(DEPTH));
   assign empty = (level_q == '0);
   assign level = level_q;
   assign dout  = mem_q[rd_ptr_q];

   always_comb begin
      do_push = push && !full;
      do_pop  = pop && !empty;
      level_d = level_q;
      unique case ({do_push, do_pop})
         2'b10:   level_d = level_q + LW'(1);
         2'b01:   level_d = level_q - LW'(1);
         default: level_d = level_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         level_q <= level_d;
         if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      end
   end

   // Storage needs no reset: entries are only ever read below the level count.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= din;
   end

endmodule

// File: rtl/fb_port_arbiter.sv
// Arbitrates the single-port framebuffer RAM between LCD reads (priority) and buffered SPI writes.
module fb_port_arbiter
   import fb_pkg::*;
#(
   parameter int unsigned ADDR_W       = FB_ADDR_W,
   parameter int unsigned DATA_W       = FB_DATA_W,
   parameter int unsigned WFIFO_DEPTH  = 4,
   parameter int unsigned MAX_WR_STALL = 8
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           rd_req,
   input  logic [ADDR_W-1:0]              rd_addr,
   output logic                           rd_ack,
   output logic                           rd_valid,
   output logic [DATA_W-1:0]              rd_data,
   input  logic                           wr_req,
   input  logic [ADDR_W-1:0]              wr_addr,
   input  logic [DATA_W-1:0]              wr_data,
   output logic                           wr_ready,
   output logic [$clog2(WFIFO_DEPTH):0]   wfifo_level,
   output logic                           mem_en,
   output logic                           mem_we,
   output logic [ADDR_W-1:0]              mem_addr,
   output logic [DATA_W-1:0]              mem_wdata,
   input  logic [DATA_W-1:0]              mem_rdata
);

   localparam int unsigned STALL_W = $clog2(MAX_WR_STALL + 1);

   logic [ADDR_W+DATA_W-1:0] head;
   logic [ADDR_W-1:0]        head_addr;
   logic [DATA_W-1:0]        head_data;
   logic                     fifo_full, fifo_empty;
   logic                     rd_rdy, force_wr;
   grant_e                   grant;

   logic                     rd_ack_q, rd_valid_q, mem_en_q, mem_we_q;
   logic [ADDR_W-1:0]        mem_addr_q;
   logic [DATA_W-1:0]        mem_wdata_q, rd_hold_q;
   logic [STALL_W-1:0]       stall_cnt_q;

   sync_fifo #(
      .WIDTH (ADDR_W + DATA_W),
      .DEPTH (WFIFO_DEPTH)
   ) u_wfifo (
      .clk   (clk),
      .rst   (rst),
      .push  (wr_req && !fifo_full),
      .din   ({wr_addr, wr_data}),
      .pop   (grant == G_WR),
      .dout  (head),
      .level (wfifo_level),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign head_addr = head[ADDR_W+DATA_W-1:DATA_W];
   assign head_data = head[DATA_W-1:0];

   // rd_ack in the term stops a second grant while the requester is still dropping rd_req.
   always_comb begin
      rd_rdy   = rd_req && !rd_ack_q;
      force_wr = (stall_cnt_q == STALL_W'(MAX_WR_STALL));
      if (!fifo_empty && (force_wr || !rd_rdy)) begin
         grant = G_WR;
      end else if (rd_rdy) begin
         grant = G_RD;
      end else begin
         grant = G_NONE;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ack_q    <= 1'b0;
         rd_valid_q  <= 1'b0;
         rd_hold_q   <= '0;
         mem_en_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         stall_cnt_q <= '0;
      end else begin
         rd_ack_q   <= (grant == G_RD);
         rd_valid_q <= rd_ack_q;
         mem_en_q   <= (grant != G_NONE);
         mem_we_q   <= (grant == G_WR);
         if (rd_valid_q) rd_hold_q <= mem_rdata;

         unique case (grant)
            G_RD: mem_addr_q <= rd_addr;
            G_WR: begin
               mem_addr_q  <= head_addr;
               mem_wdata_q <= head_data;
            end
            default: ;
         endcase

         if (grant == G_WR || fifo_empty) begin
            stall_cnt_q <= '0;
         end else if (grant == G_RD && !force_wr) begin
            stall_cnt_q <= stall_cnt_q + STALL_W'(1);
         end
      end
   end

   // RAM data is live in the rd_valid cycle; the hold register keeps it visible afterwards.
   assign rd_data   = rd_valid_q ? mem_rdata : rd_hold_q;
   assign rd_ack    = rd_ack_q;
   assign rd_valid  = rd_valid_q;
   assign wr_ready  = !fifo_full;
   assign mem_en    = mem_en_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;

endmodule
